psram_cmd_sched: RTL and testbench

- Command scheduler between the AXI4 front end and the PSRAM PHY sequencer inside the AXI4 PSRAM controller.
- Round-robin arbitrates between pending read and write byte-burst requests.
- Splits each request into segments that respect the device page boundary and the APB-programmed max-CE-low byte budget.
- Issues one segment at a time to the PHY and enforces a programmable minimum CE-high gap between segments.

---
 rtl/psram_cmd_sched.sv | 212 +++++++++++++++++++++
 tb/tb_psram_cmd_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_cmd_sched.sv
// psram_cmd_sched
// Command scheduler between the AXI4 front end and the PSRAM PHY sequencer.
// Arbitrates round-robin between pending read and write byte-burst requests,
// splits each request into segments that never cross a device page and never
// exceed the programmed max-CE-low byte budget, issues one segment at a time
// to the PHY and enforces a programmable CE-high gap between segments.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   cfg_max_bytes_i         max segment bytes-1 (tCEM budget)
//   cfg_cph_i               CE-high gap in clk cycles between segments
//   rd_req_* / wr_req_*     request channels (valid/ready, addr, bytes-1)
//   cmd_*                   segment command to the PHY (valid/ready)
//   phy_done_i              one-cycle pulse: segment finished, CE high
//   rd_done_o / wr_done_o   one-cycle pulse: whole request complete
//   busy_o                  scheduler not idle
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid and its payload stable until then;
// ready may depend combinationally on valid.
module psram_cmd_sched #(
    parameter int ADDR_W     = 25,
    parameter int LEN_W      = 12,
    parameter int PAGE_BYTES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [LEN_W-1:0]  cfg_max_bytes_i,
    input  logic [7:0]        cfg_cph_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_req_addr_i,
    input  logic [LEN_W-1:0]  rd_req_len_i,
    input  logic              wr_req_valid_i,
    output logic              wr_req_ready_o,
    input  logic [ADDR_W-1:0] wr_req_addr_i,
    input  logic [LEN_W-1:0]  wr_req_len_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic              cmd_we_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [LEN_W-1:0]  cmd_len_o,
    output logic              cmd_last_o,
    input  logic              phy_done_i,
    output logic              rd_done_o,
    output logic              wr_done_o,
    output logic              busy_o
);

    // Byte counts need one more bit than the bytes-1 length fields.
    localparam int CNT_W = LEN_W + 1;
    localparam int PG_W  = $clog2(PAGE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   seg_q;
    logic [LEN_W-1:0]   len_q;
    logic               last_q;
    logic [7:0]         gap_q;
    logic               rr_wr_q;     // 1: write preferred on a tie
    logic               rd_done_q;
    logic               wr_done_q;

    logic               grant_rd, grant_wr;
    logic               load_seg, gap_load, done_set;
    logic [ADDR_W-1:0]  src_addr;
    logic [CNT_W-1:0]   src_rem;
    logic [CNT_W-1:0]   seg_next;

    // Segment = min(remaining, budget, bytes left in the current page).
    function automatic logic [CNT_W-1:0] seg_calc(
        input logic [PG_W-1:0]  off,
        input logic [CNT_W-1:0] rem,
        input logic [LEN_W-1:0] max_m1
    );
        logic [CNT_W-1:0] lim_cfg;
        logic [31:0]      room;
        logic [CNT_W-1:0] s;
        lim_cfg = {1'b0, max_m1} + CNT_W'(1);
        room    = 32'(PAGE_BYTES) - 32'(off);
        s       = rem;
        if (lim_cfg < s) s = lim_cfg;
        if (room < 32'(s)) s = CNT_W'(room);
        return s;
    endfunction

    // Source of the next segment: the granted request when leaving IDLE,
    // otherwise the already-advanced request registers.
    always_comb begin
        src_addr = addr_q;
        src_rem  = rem_q;
        if (state_q == IDLE) begin
            if (grant_wr) begin
                src_addr = wr_req_addr_i;
                src_rem  = {1'b0, wr_req_len_i} + CNT_W'(1);
            end else begin
                src_addr = rd_req_addr_i;
                src_rem  = {1'b0, rd_req_len_i} + CNT_W'(1);
            end
        end
    end

    assign seg_next = seg_calc(src_addr[PG_W-1:0], src_rem, cfg_max_bytes_i);

    always_comb begin
        state_d  = state_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        load_seg = 1'b0;
        gap_load = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req_valid_i && (!wr_req_valid_i || !rr_wr_q)) begin
                    grant_rd = 1'b1;
                end else if (wr_req_valid_i) begin
                    grant_wr = 1'b1;
                end
                if (grant_rd || grant_wr) begin
                    state_d  = ISSUE;
                    load_seg = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (phy_done_i) begin
                    done_set = (rem_q == '0);
                    if (cfg_cph_i == 8'd0) begin
                        state_d  = (rem_q == '0) ? IDLE : ISSUE;
                        load_seg = (rem_q != '0);
                    end else begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d  = (rem_q == '0) ? IDLE : ISSUE;
                    load_seg = (rem_q != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            seg_q     <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
            gap_q     <= 8'd0;
            rr_wr_q   <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_done_q <= done_set & ~we_q;
            wr_done_q <= done_set & we_q;
            if (grant_rd || grant_wr) begin
                we_q    <= grant_wr;
                addr_q  <= src_addr;
                rem_q   <= src_rem;
                rr_wr_q <= ~rr_wr_q;
            end
            // Segment fields are frozen here so cfg changes only affect
            // the next segment.
            if (load_seg) begin
                seg_q  <= seg_next;
                len_q  <= LEN_W'(seg_next - CNT_W'(1));
                last_q <= (seg_next == src_rem);
            end
            // Address wraps naturally at 2^ADDR_W.
            if (state_q == ISSUE && cmd_ready_i) begin
                addr_q <= addr_q + ADDR_W'(seg_q);
                rem_q  <= rem_q - seg_q;
            end
            if (gap_load) begin
                gap_q <= cfg_cph_i;
            end else if (state_q == GAP) begin
                gap_q <= gap_q - 8'd1;
            end
        end
    end

    assign rd_req_ready_o = grant_rd;
    assign wr_req_ready_o = grant_wr;
    assign cmd_valid_o    = (state_q == ISSUE);
    assign cmd_we_o       = cmd_valid_o & we_q;
    assign cmd_addr_o     = cmd_valid_o ? addr_q : '0;
    assign cmd_len_o      = cmd_valid_o ? len_q : '0;
    assign cmd_last_o     = cmd_valid_o & last_q;
    assign rd_done_o      = rd_done_q;
    assign wr_done_o      = wr_done_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_psram_cmd_sched.sv
// Directed bench for psram_cmd_sched: request driver, PHY model, command
// scoreboard and done-pulse counters.
module tb_psram_cmd_sched;

    localparam int ADDR_W = 25;
    localparam int LEN_W  = 12;
    localparam int CMD_W  = 1 + ADDR_W + LEN_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LEN_W-1:0]  cfg_max = '0;
    logic [7:0]        cfg_cph = '0;
    logic              rd_v = 1'b0, wr_v = 1'b0;
    logic              rd_rdy, wr_rdy;
    logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
    logic [LEN_W-1:0]  rd_len = '0, wr_len = '0;
    logic              cmd_valid, cmd_ready = 1'b0, cmd_we, cmd_last;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              phy_done = 1'b0;
    logic              rd_done, wr_done, busy;

    int checks = 0;
    int errors = 0;
    int rd_done_cnt = 0;
    int wr_done_cnt = 0;
    logic [CMD_W-1:0] exp_q[$];

    psram_cmd_sched dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_max_bytes_i(cfg_max), .cfg_cph_i(cfg_cph),
        .rd_req_valid_i(rd_v), .rd_req_ready_o(rd_rdy),
        .rd_req_addr_i(rd_addr), .rd_req_len_i(rd_len),
        .wr_req_valid_i(wr_v), .wr_req_ready_o(wr_rdy),
        .wr_req_addr_i(wr_addr), .wr_req_len_i(wr_len),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_we_o(cmd_we), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
        .cmd_last_o(cmd_last), .phy_done_i(phy_done),
        .rd_done_o(rd_done), .wr_done_o(wr_done), .busy_o(busy)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk(input logic we, input logic [ADDR_W-1:0] a,
                                           input logic [LEN_W-1:0] l, input logic last);
        return {we, a, l, last};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted command is compared with the queue head
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_cmd", {cmd_we, cmd_addr, cmd_len, cmd_last}, 64'h0);
            end else begin
                chk("sb_cmd", {cmd_we, cmd_addr, cmd_len, cmd_last}, exp_q.pop_front());
            end
        end
        if (rd_done) rd_done_cnt++;
        if (wr_done) wr_done_cnt++;
    end

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        rd_v = 1'b0; wr_v = 1'b0; cmd_ready = 1'b0; phy_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_req(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (we) begin wr_v = 1'b1; wr_addr = a; wr_len = l; end
        else    begin rd_v = 1'b1; rd_addr = a; rd_len = l; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (we ? wr_rdy : rd_rdy) begin ok = 1'b1; break; end
        end
        chk("req_grant", 64'(ok), 64'h1);
        @(posedge clk); #1;
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

    // Waits for cmd_valid (counting idle negedges), keeps ready low for
    // low_cycles checking the payload stays at the expected value, then
    // accepts the command.
    task automatic take_cmd(input int low_cycles, output int idle);
        logic ok;
        ok = 1'b0;
        idle = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_valid) begin ok = 1'b1; break; end
            idle++;
        end
        chk("cmd_seen", 64'(ok), 64'h1);
        if (ok) begin
            for (int i = 0; i < low_cycles; i++) begin
                if (i > 0) @(negedge clk);
                if (exp_q.size() > 0)
                    chk("cmd_hold", {cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_last}, {1'b1, exp_q[0]});
            end
            @(posedge clk); #1 cmd_ready = 1'b1;
            @(posedge clk); #1 cmd_ready = 1'b0;
        end
    endtask

    task automatic pulse_done(input int lat);
        repeat (lat) @(posedge clk);
        #1 phy_done = 1'b1;
        @(posedge clk); #1 phy_done = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        chk("wait_idle", 64'(ok), 64'h1);
    endtask

    initial begin
        int idle;
        int cnt0;
        logic exp_rd;

        // reset state
        #1;
        chk("rst_outputs", {cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_last, rd_rdy, wr_rdy, rd_done, wr_done, busy}, 64'h0);
        do_reset();
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_cmd", {cmd_valid, cmd_addr, cmd_len}, 64'h0);

        // single-segment read, gap 4
        cfg_max = 12'h0FF; cfg_cph = 8'd4;
        exp_q.push_back(mk(1'b0, 25'h000100, 12'h00F, 1'b1));
        send_req(1'b0, 25'h000100, 12'h00F);
        take_cmd(1, idle);
        pulse_done(2);
        @(negedge clk);
        chk("t1_rd_done", {rd_done, wr_done, busy}, 64'b101);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t1_busy_gap", {rd_done, busy}, 64'b01);
        end
        @(negedge clk);
        chk("t1_busy_drop", 64'(busy), 64'h0);
        chk("t1_rd_cnt", 64'(rd_done_cnt), 64'd1);

        // write crossing a page boundary
        exp_q.push_back(mk(1'b1, 25'h0003F0, 12'h00F, 1'b0));
        exp_q.push_back(mk(1'b1, 25'h000400, 12'h00F, 1'b1));
        send_req(1'b1, 25'h0003F0, 12'h01F);
        take_cmd(1, idle);
        pulse_done(1);
        take_cmd(1, idle);
        chk("t2_gap_cycles", 64'(idle), 64'd4);
        pulse_done(1);
        wait_idle();
        chk("t2_wr_cnt", 64'(wr_done_cnt), 64'd1);

        // read split by the byte budget into four segments
        cfg_cph = 8'd2;
        cnt0 = rd_done_cnt;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(1'b0, 25'(i * 256), 12'h0FF, (i == 3)));
        send_req(1'b0, 25'h000000, 12'h3FF);
        for (int i = 0; i < 4; i++) begin
            take_cmd(1, idle);
            if (i < 3) chk("t3_no_early_done", 64'(rd_done_cnt - cnt0), 64'd0);
            pulse_done(1);
        end
        wait_idle();
        chk("t3_rd_once", 64'(rd_done_cnt - cnt0), 64'd1);
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // arbitration: both held, grants alternate starting with read
        do_reset();
        cfg_cph = 8'd1;
        rd_addr = 25'h000010; rd_len = 12'h003;
        wr_addr = 25'h000020; wr_len = 12'h007;
        cnt0 = rd_done_cnt + wr_done_cnt;
        @(posedge clk); #1 rd_v = 1'b1; wr_v = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic ok;
            ok = 1'b0;
            exp_rd = (g % 2 == 0);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rd_rdy || wr_rdy) begin ok = 1'b1; break; end
            end
            chk("t4_grant_seen", 64'(ok), 64'h1);
            chk("t4_grant_who", {rd_rdy, wr_rdy}, {62'h0, exp_rd, ~exp_rd});
            if (exp_rd) exp_q.push_back(mk(1'b0, 25'h000010, 12'h003, 1'b1));
            else        exp_q.push_back(mk(1'b1, 25'h000020, 12'h007, 1'b1));
            @(posedge clk); #1;
            if (g == 3) begin rd_v = 1'b0; wr_v = 1'b0; end
            take_cmd(1, idle);
            pulse_done(1);
        end
        wait_idle();
        chk("t4_done_cnt", 64'(rd_done_cnt + wr_done_cnt - cnt0), 64'd4);

        // cph=0, ready held low 3 cycles
        cfg_cph = 8'd0;
        exp_q.push_back(mk(1'b0, 25'h0003FC, 12'h003, 1'b0));
        exp_q.push_back(mk(1'b0, 25'h000400, 12'h003, 1'b1));
        send_req(1'b0, 25'h0003FC, 12'h007);
        take_cmd(3, idle);
        pulse_done(1);
        take_cmd(1, idle);
        chk("t5_back_to_back", 64'(idle), 64'd0);
        pulse_done(1);
        wait_idle();

        // reset during WAIT of a two-segment write
        cfg_cph = 8'd2;
        cnt0 = wr_done_cnt;
        exp_q.push_back(mk(1'b1, 25'h0003F8, 12'h007, 1'b0));
        send_req(1'b1, 25'h0003F8, 12'h00F);
        take_cmd(1, idle);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_last, rd_rdy, wr_rdy, rd_done, wr_done, busy}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_done(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_quiet", {cmd_valid, wr_done, busy}, 64'h0);
        end
        chk("t6_no_wr_done", 64'(wr_done_cnt - cnt0), 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
